// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with stall, flush and WB-to-capture bypass
//
// Purpose: registers decoded operands and control between ID and EX. On each
// capture the rs/rt values are bypassed from the WB write port when WB writes
// the same (non-zero) register, so the ALU sees current operands one cycle later.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   stall_i, flush_i             hold outputs / load a bubble (flush wins over stall)
//   rs/rt_data_i, imm_i          register-file reads and raw immediate
//   rs/rt/rd_addr_i              source and destination register numbers
//   alu_ctrl_i, alu_src_i,
//   reg_dst_i, *_i control       decoded control from ID
//   wb_we_i, wb_addr_i, wb_data_i  WB-stage register-file write port
//   data1_o, data2_o             ALU operands (data2 after ALUSrc select)
//   rt_fwd_o                     bypassed rt value (store data)
//   alu_ctrl_o, wr_addr_o        ALU op and destination after RegDst select
//   rs/rt_addr_o                 source numbers for the forwarding unit
//   reg_write_o .. mem_to_reg_o  pass-through control
//   valid_o                      1 = real instruction, 0 = bubble
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int IMM_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [IMM_W-1:0]  imm_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [2:0]        alu_ctrl_i,
  input  logic              alu_src_i,
  input  logic              reg_dst_i,
  input  logic              reg_write_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              mem_to_reg_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [DATA_W-1:0] rt_fwd_o,
  output logic [2:0]        alu_ctrl_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [ADDR_W-1:0] rs_addr_o,
  output logic [ADDR_W-1:0] rt_addr_o,
  output logic              reg_write_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              mem_to_reg_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data1_q, data1_d;
  logic [DATA_W-1:0] data2_q, data2_d;
  logic [DATA_W-1:0] rt_fwd_q, rt_fwd_d;
  logic [2:0]        alu_ctrl_q, alu_ctrl_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rs_addr_q, rs_addr_d;
  logic [ADDR_W-1:0] rt_addr_q, rt_addr_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              valid_q, valid_d;

  logic [DATA_W-1:0] rs_eff, rt_eff, imm_ext;
  logic              wb_hit_rs, wb_hit_rt;

  // Register 0 is hard-wired, so a WB write to it must never be bypassed.
  assign wb_hit_rs = wb_we_i && (wb_addr_i != '0) && (wb_addr_i == rs_addr_i);
  assign wb_hit_rt = wb_we_i && (wb_addr_i != '0) && (wb_addr_i == rt_addr_i);
  assign rs_eff    = wb_hit_rs ? wb_data_i : rs_data_i;
  assign rt_eff    = wb_hit_rt ? wb_data_i : rt_data_i;
  assign imm_ext   = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};

  always_comb begin
    data1_d      = data1_q;
    data2_d      = data2_q;
    rt_fwd_d     = rt_fwd_q;
    alu_ctrl_d   = alu_ctrl_q;
    wr_addr_d    = wr_addr_q;
    rs_addr_d    = rs_addr_q;
    rt_addr_d    = rt_addr_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    valid_d      = valid_q;
    if (flush_i) begin
      // Bubble: everything zero so downstream state is deterministic.
      data1_d      = '0;
      data2_d      = '0;
      rt_fwd_d     = '0;
      alu_ctrl_d   = '0;
      wr_addr_d    = '0;
      rs_addr_d    = '0;
      rt_addr_d    = '0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      valid_d      = 1'b0;
    end else if (!stall_i) begin
      data1_d      = rs_eff;
      data2_d      = alu_src_i ? imm_ext : rt_eff;
      rt_fwd_d     = rt_eff;
      alu_ctrl_d   = alu_ctrl_i;
      wr_addr_d    = reg_dst_i ? rd_addr_i : rt_addr_i;
      rs_addr_d    = rs_addr_i;
      rt_addr_d    = rt_addr_i;
      reg_write_d  = reg_write_i;
      mem_read_d   = mem_read_i;
      mem_write_d  = mem_write_i;
      mem_to_reg_d = mem_to_reg_i;
      valid_d      = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data1_q      <= '0;
      data2_q      <= '0;
      rt_fwd_q     <= '0;
      alu_ctrl_q   <= '0;
      wr_addr_q    <= '0;
      rs_addr_q    <= '0;
      rt_addr_q    <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      rt_fwd_q     <= rt_fwd_d;
      alu_ctrl_q   <= alu_ctrl_d;
      wr_addr_q    <= wr_addr_d;
      rs_addr_q    <= rs_addr_d;
      rt_addr_q    <= rt_addr_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      valid_q      <= valid_d;
    end
  end

  assign data1_o      = data1_q;
  assign data2_o      = data2_q;
  assign rt_fwd_o     = rt_fwd_q;
  assign alu_ctrl_o   = alu_ctrl_q;
  assign wr_addr_o    = wr_addr_q;
  assign rs_addr_o    = rs_addr_q;
  assign rt_addr_o    = rt_addr_q;
  assign reg_write_o  = reg_write_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign mem_to_reg_o = mem_to_reg_q;
  assign valid_o      = valid_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - directed self-checking bench for id_ex_stage_reg
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [31:0] rs_data, rt_data, wb_data;
  logic [15:0] imm;
  logic [4:0]  rs_addr, rt_addr, rd_addr, wb_addr;
  logic [2:0]  alu_ctrl;
  logic        alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg, wb_we;
  logic [31:0] data1, data2, rt_fwd;
  logic [2:0]  alu_ctrl_out;
  logic [4:0]  wr_addr, rs_addr_out, rt_addr_out;
  logic        reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out, valid;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .rs_data_i(rs_data), .rt_data_i(rt_data), .imm_i(imm),
    .rs_addr_i(rs_addr), .rt_addr_i(rt_addr), .rd_addr_i(rd_addr),
    .alu_ctrl_i(alu_ctrl), .alu_src_i(alu_src), .reg_dst_i(reg_dst),
    .reg_write_i(reg_write), .mem_read_i(mem_read), .mem_write_i(mem_write),
    .mem_to_reg_i(mem_to_reg), .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .data1_o(data1), .data2_o(data2), .rt_fwd_o(rt_fwd), .alu_ctrl_o(alu_ctrl_out),
    .wr_addr_o(wr_addr), .rs_addr_o(rs_addr_out), .rt_addr_o(rt_addr_out),
    .reg_write_o(reg_write_out), .mem_read_o(mem_read_out), .mem_write_o(mem_write_out),
    .mem_to_reg_o(mem_to_reg_out), .valid_o(valid)
  );

  // Advance one edge and sample away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; flush = 0;
    rs_data = 0; rt_data = 0; imm = 0; rs_addr = 0; rt_addr = 0; rd_addr = 0;
    alu_ctrl = 0; alu_src = 0; reg_dst = 0; reg_write = 0; mem_read = 0;
    mem_write = 0; mem_to_reg = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic test_reset();
    logic [31:0] packed_out;
    idle_inputs();
    rst = 1;
    rs_data = 32'h1234; rt_data = 32'h5678; imm = 16'h00F0; rs_addr = 5'd1;
    rt_addr = 5'd2; rd_addr = 5'd3; alu_ctrl = 3'b011; alu_src = 1; reg_dst = 1;
    reg_write = 1; mem_read = 1; mem_write = 1; mem_to_reg = 1;
    wb_we = 1; wb_addr = 5'd1; wb_data = 32'h99;
    step();
    tests_run++;
    if ({data1, data2, rt_fwd} !== 96'd0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h %h %h expected 0", data1, data2, rt_fwd);
    end
    packed_out = {14'd0, alu_ctrl_out, wr_addr, rs_addr_out, rt_addr_out,
                  reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out, valid};
    tests_run++;
    if (packed_out !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %h expected 0", packed_out);
    end
    // Release: the held inputs are captured on the next edge.
    rst = 0;
    wb_we = 0;
    step();
    tests_run++;
    if (valid !== 1'b1 || data1 !== 32'h1234 || data2 !== 32'h000000F0 || wr_addr !== 5'd3) begin
      tests_failed++;
      $display("FAIL reset_release: got v=%b d1=%h d2=%h wa=%0d expected v=1 d1=1234 d2=000000f0 wa=3",
               valid, data1, data2, wr_addr);
    end
  endtask

  task automatic test_basic_add();
    idle_inputs();
    rs_data = 32'd5; rt_data = 32'd7; alu_ctrl = 3'b010; reg_dst = 1; rd_addr = 5'd9;
    rs_addr = 5'd1; rt_addr = 5'd2; reg_write = 1;
    step();
    tests_run++;
    if (data1 !== 32'd5 || data2 !== 32'd7 || alu_ctrl_out !== 3'b010 || wr_addr !== 5'd9 ||
        valid !== 1'b1 || reg_write_out !== 1'b1 || rs_addr_out !== 5'd1 || rt_addr_out !== 5'd2) begin
      tests_failed++;
      $display("FAIL basic_add: got d1=%0d d2=%0d op=%b wa=%0d v=%b rw=%b rs=%0d rt=%0d expected 5 7 010 9 1 1 1 2",
               data1, data2, alu_ctrl_out, wr_addr, valid, reg_write_out, rs_addr_out, rt_addr_out);
    end
    reg_dst = 0; alu_ctrl = 3'b111;
    step();
    tests_run++;
    if (wr_addr !== 5'd2 || alu_ctrl_out !== 3'b111) begin
      tests_failed++;
      $display("FAIL regdst_rt_op111: got wa=%0d op=%b expected wa=2 op=111", wr_addr, alu_ctrl_out);
    end
  endtask

  task automatic test_sign_extend();
    idle_inputs();
    alu_src = 1; rt_data = 32'h3333; imm = 16'hFFFC;
    step();
    tests_run++;
    if (data2 !== 32'hFFFFFFFC || rt_fwd !== 32'h3333) begin
      tests_failed++;
      $display("FAIL sext_neg: got d2=%h rtf=%h expected fffffffc 00003333", data2, rt_fwd);
    end
    imm = 16'h7FFF;
    step();
    tests_run++;
    if (data2 !== 32'h00007FFF) begin
      tests_failed++;
      $display("FAIL sext_pos: got %h expected 00007fff", data2);
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    wb_we = 1; wb_addr = 5'd3; wb_data = 32'hAA; rs_addr = 5'd3; rs_data = 32'h11;
    rt_addr = 5'd6; rt_data = 32'h22;
    step();
    tests_run++;
    if (data1 !== 32'hAA || data2 !== 32'h22) begin
      tests_failed++;
      $display("FAIL bypass_rs: got d1=%h d2=%h expected 000000aa 00000022", data1, data2);
    end
    wb_addr = 5'd0; rs_addr = 5'd0; rt_addr = 5'd0;
    step();
    tests_run++;
    if (data1 !== 32'h11 || data2 !== 32'h22) begin
      tests_failed++;
      $display("FAIL bypass_r0: got d1=%h d2=%h expected 00000011 00000022", data1, data2);
    end
    wb_we = 0; wb_addr = 5'd3; rs_addr = 5'd3;
    step();
    tests_run++;
    if (data1 !== 32'h11) begin
      tests_failed++;
      $display("FAIL bypass_we0: got %h expected 00000011", data1);
    end
  endtask

  task automatic test_stall_flush();
    idle_inputs();
    rs_data = 32'd10; rt_data = 32'd20; alu_ctrl = 3'b010; reg_write = 1;
    reg_dst = 1; rd_addr = 5'd8; rs_addr = 5'd4; rt_addr = 5'd5;
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rs_data = 32'd100 + i; rt_data = 32'd200 + i; alu_ctrl = 3'b100;
      rd_addr = 5'd20 + 5'(i); reg_write = 0;
      step();
      tests_run++;
      if (data1 !== 32'd10 || data2 !== 32'd20 || alu_ctrl_out !== 3'b010 ||
          wr_addr !== 5'd8 || reg_write_out !== 1'b1 || valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall_hold_%0d: got d1=%0d d2=%0d op=%b wa=%0d rw=%b v=%b expected 10 20 010 8 1 1",
                 i, data1, data2, alu_ctrl_out, wr_addr, reg_write_out, valid);
      end
    end
    flush = 1; reg_write = 1;
    step();
    tests_run++;
    if (reg_write_out !== 1'b0 || valid !== 1'b0 || alu_ctrl_out !== 3'b000 ||
        wr_addr !== 5'd0 || data1 !== 32'd0 || data2 !== 32'd0) begin
      tests_failed++;
      $display("FAIL flush_over_stall: got rw=%b v=%b op=%b wa=%0d d1=%h d2=%h expected all 0",
               reg_write_out, valid, alu_ctrl_out, wr_addr, data1, data2);
    end
    // Reset must win even while stalled.
    flush = 0; stall = 0;
    step();
    stall = 1; rst = 1;
    step();
    tests_run++;
    if (valid !== 1'b0 || data1 !== 32'd0 || reg_write_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_in_stall: got v=%b d1=%h rw=%b expected 0 0 0", valid, data1, reg_write_out);
    end
    rst = 0; stall = 0;
  endtask

  task automatic test_store_bypass();
    idle_inputs();
    mem_write = 1; mem_read = 0; mem_to_reg = 0; rt_addr = 5'd4; rt_data = 32'h1;
    wb_we = 1; wb_addr = 5'd4; wb_data = 32'h55; alu_src = 1; imm = 16'h8001;
    rs_addr = 5'd2; rs_data = 32'h40;
    step();
    tests_run++;
    if (rt_fwd !== 32'h55 || data2 !== 32'hFFFF8001 || data1 !== 32'h40 || mem_write_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL store_bypass: got rtf=%h d2=%h d1=%h mw=%b expected 00000055 ffff8001 00000040 1",
               rt_fwd, data2, data1, mem_write_out);
    end
    mem_write = 0; mem_read = 1; mem_to_reg = 1; wb_we = 0;
    step();
    tests_run++;
    if (mem_read_out !== 1'b1 || mem_to_reg_out !== 1'b1 || mem_write_out !== 1'b0 || rt_fwd !== 32'h1) begin
      tests_failed++;
      $display("FAIL load_ctrl: got mr=%b m2r=%b mw=%b rtf=%h expected 1 1 0 00000001",
               mem_read_out, mem_to_reg_out, mem_write_out, rt_fwd);
    end
  endtask

  initial begin
    idle_inputs();
    #2;
    test_reset();
    test_basic_add();
    test_sign_extend();
    test_bypass();
    test_stall_flush();
    test_store_bypass();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
